// File: rtl/pcm_pkg.sv
// pcm_pkg: PCM sample type, default pacing and offer-state encoding.
// Shared by the sample pacer and the PCM-to-PWM converter.
package pcm_pkg;
    localparam int PCM_W = 16;
    localparam int CLK_PER_SAMPLE_DEF = 2268;
    typedef logic signed [PCM_W-1:0] pcm_sample_t;
    typedef enum logic {IDLE, OFFER} offer_state_t;
endpackage

// File: rtl/pcm_sample_pacer_fifo.sv
// sync_fifo: single-clock FIFO with the head word visible combinationally on dout.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter type T = logic [15:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    always_comb begin
        wr_d = push ? wr_q + AW'(1) : wr_q;
        rd_d = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= din;
    end
    assign dout = mem[rd_q];
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/pcm_sample_pacer.sv
// pcm_sample_pacer: buffers producer PCM samples and releases exactly one per
// audio sample period to the converter, flagging underruns and missed deadlines.
module pcm_sample_pacer
    import pcm_pkg::*;
#(
    parameter int CLK_PER_SAMPLE = CLK_PER_SAMPLE_DEF,
    parameter int DEPTH = 16,
    parameter int PCM_W = pcm_pkg::PCM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [PCM_W-1:0]       in_data,
    output logic                   in_ready,
    output logic                   PCM_valid,
    output logic [PCM_W-1:0]       PCM_data,
    input  logic                   PCM_ack,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   underrun,
    output logic                   missed_tick,
    input  logic                   clr_flags
);
    localparam int CW = $clog2(CLK_PER_SAMPLE);
    typedef logic [PCM_W-1:0] word_t;
    logic [CW-1:0] cnt_q, cnt_d;
    offer_state_t state_q, state_d;
    word_t data_q, data_d, head;
    logic under_q, under_d, miss_q, miss_d;
    logic tick, push, pop, serve, full, empty;

    sync_fifo #(.DEPTH(DEPTH), .T(word_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(in_data),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fill_level)
    );

    always_comb begin
        tick = cnt_q == CW'(CLK_PER_SAMPLE - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        push = in_valid & in_ready;
        // an ack on the tick cycle frees the slot, so that tick is served, not missed
        serve = tick & ((state_q == IDLE) | PCM_ack);
        pop = serve & ~empty;
        state_d = serve ? OFFER : (PCM_ack ? IDLE : state_q);
        data_d = pop ? head : data_q;
        under_d = (under_q & ~clr_flags) | (serve & empty);
        miss_d = (miss_q & ~clr_flags) | (tick & ~serve);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            state_q <= IDLE;
            data_q <= '0;
            under_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            state_q <= state_d;
            data_q <= data_d;
            under_q <= under_d;
            miss_q <= miss_d;
        end
    end

    assign in_ready = rst & ~full;
    assign PCM_valid = state_q == OFFER;
    assign PCM_data = data_q;
    assign underrun = under_q;
    assign missed_tick = miss_q;
endmodule

// File: tb/tb_pcm_sample_pacer.sv
// tb_pcm_sample_pacer: directed tests with a transfer scoreboard; CLK_PER_SAMPLE=8, DEPTH=4.
module tb_pcm_sample_pacer;
    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, PCM_ack = 1'b0, clr_flags = 1'b0;
    logic [15:0] in_data = '0;
    logic in_ready, PCM_valid, underrun, missed_tick;
    logic [15:0] PCM_data, mon_e;
    logic [2:0] fill_level;
    int checks = 0, errors = 0, edge_n = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    pcm_sample_pacer #(.CLK_PER_SAMPLE(8), .DEPTH(4), .PCM_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .PCM_valid(PCM_valid),
        .PCM_data(PCM_data),
        .PCM_ack(PCM_ack),
        .fill_level(fill_level),
        .underrun(underrun),
        .missed_tick(missed_tick),
        .clr_flags(clr_flags)
    );

    // edge_n = number of clock edges since reset release
    always @(posedge clk or negedge rst) edge_n <= !rst ? 0 : edge_n + 1;

    // every accepted transfer must carry the next expected sample
    always @(negedge clk) begin
        if (rst && PCM_valid && PCM_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer: got %h but none expected", PCM_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (PCM_data !== mon_e) begin
                    errors++;
                    $display("FAIL xfer: got %h expected %h", PCM_data, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data = d;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        chk("drain", exp_q.size(), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        PCM_ack = 1'b0;
        clr_flags = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset / idle / underrun with clear-vs-set priority
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", PCM_valid, 0);
        chk("rst_data", PCM_data, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_flags", {underrun, missed_tick}, 0);
        rst = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);
        goto(7);
        chk("pre_tick_valid", PCM_valid, 0);
        chk("pre_tick_under", underrun, 0);
        clr_flags = 1'b1;
        goto(8);
        clr_flags = 1'b0;
        chk("t1_valid", PCM_valid, 1);
        chk("t1_data", PCM_data, 0);
        chk("t1_under_setwins", underrun, 1);
        exp_q.push_back(16'h0000);
        PCM_ack = 1'b1;
        goto(9);
        PCM_ack = 1'b0;
        chk("t1_drop", PCM_valid, 0);
        clr_flags = 1'b1;
        goto(10);
        clr_flags = 1'b0;
        chk("t1_clr", underrun, 0);

        // normal flow, then re-offer of last sample on underrun
        do_reset();
        push(16'h8003);
        chk("t2_fill1", fill_level, 1);
        push(16'h8008);
        chk("t2_fill2", fill_level, 2);
        goto(7);
        chk("t2_pre", PCM_valid, 0);
        goto(8);
        chk("t2_v1", PCM_valid, 1);
        chk("t2_fill_a", fill_level, 1);
        goto(10);
        PCM_ack = 1'b1;
        goto(11);
        PCM_ack = 1'b0;
        chk("t2_drop1", PCM_valid, 0);
        goto(16);
        chk("t2_v2", PCM_valid, 1);
        chk("t2_fill_b", fill_level, 0);
        goto(18);
        PCM_ack = 1'b1;
        goto(19);
        PCM_ack = 1'b0;
        chk("t2_under0", underrun, 0);
        goto(24);
        chk("t2_under1", underrun, 1);
        chk("t2_reoffer", PCM_data, 16'h8008);
        exp_q.push_back(16'h8008);
        PCM_ack = 1'b1;
        goto(25);
        PCM_ack = 1'b0;
        chk("t2_drop3", PCM_valid, 0);

        // full FIFO back-pressure, order preserved
        do_reset();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_full_fill", fill_level, 4);
        in_valid = 1'b1;
        in_data = 16'h5555;
        exp_q.push_back(16'h5555);
        PCM_ack = 1'b1;
        goto(7);
        chk("t3_hold_ready", in_ready, 0);
        chk("t3_hold_fill", fill_level, 4);
        goto(8);
        chk("t3_pop_fill", fill_level, 3);
        chk("t3_pop_ready", in_ready, 1);
        goto(9);
        in_valid = 1'b0;
        chk("t3_refill", fill_level, 4);
        goto(16);
        chk("t3_fill16", fill_level, 3);
        goto(41);
        PCM_ack = 1'b0;
        chk("t3_empty", fill_level, 0);
        chk("t3_under", underrun, 0);

        // missed deadline
        do_reset();
        push(16'hA001);
        push(16'hA002);
        goto(8);
        chk("t4_data1", PCM_data, 16'hA001);
        chk("t4_fill1", fill_level, 1);
        goto(16);
        chk("t4_missed", missed_tick, 1);
        chk("t4_hold_data", PCM_data, 16'hA001);
        chk("t4_hold_fill", fill_level, 1);
        chk("t4_hold_valid", PCM_valid, 1);
        PCM_ack = 1'b1;
        goto(17);
        PCM_ack = 1'b0;
        chk("t4_drop", PCM_valid, 0);
        goto(24);
        chk("t4_data2", PCM_data, 16'hA002);
        chk("t4_under", underrun, 0);
        PCM_ack = 1'b1;
        goto(25);
        PCM_ack = 1'b0;
        chk("t4_sticky", missed_tick, 1);
        clr_flags = 1'b1;
        goto(26);
        clr_flags = 1'b0;
        chk("t4_clr", {underrun, missed_tick}, 0);

        // ack coincident with tick
        do_reset();
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        goto(8);
        chk("t5_data1", PCM_data, 16'hB001);
        goto(15);
        PCM_ack = 1'b1;
        goto(16);
        chk("t5_cont_valid", PCM_valid, 1);
        chk("t5_data2", PCM_data, 16'hB002);
        chk("t5_nomiss", missed_tick, 0);
        goto(17);
        PCM_ack = 1'b0;
        chk("t5_drop", PCM_valid, 0);
        goto(24);
        chk("t5_data3", PCM_data, 16'hB003);
        PCM_ack = 1'b1;
        goto(25);
        PCM_ack = 1'b0;
        chk("t5_flags", {underrun, missed_tick}, 0);

        // async reset mid-offer discards everything
        do_reset();
        push(16'hC001);
        push(16'hC002);
        push(16'hC003);
        push(16'hC004);
        goto(8);
        chk("t6_fill3", fill_level, 3);
        goto(16);
        chk("t6_missed", missed_tick, 1);
        rst = 1'b0;
        #1;
        chk("t6_async_valid", PCM_valid, 0);
        chk("t6_async_fill", fill_level, 0);
        chk("t6_async_flags", {underrun, missed_tick}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t6_rel_fill", fill_level, 0);
        push(16'hD001);
        goto(8);
        chk("t6_data", PCM_data, 16'hD001);
        PCM_ack = 1'b1;
        goto(9);
        PCM_ack = 1'b0;
        chk("t6_under", underrun, 0);
        chk("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcm_sample_pacer.md
Name: pcm_sample_pacer

Overview:
Upstream feeder for the PCM-to-PWM converter. Accepts signed 16-bit PCM samples from a producer (bus master, SD reader, tone generator) through a ready/valid interface. Buffers them in a small FIFO. Releases exactly one sample per audio sample period to the converter over the PCM_valid/PCM_data/PCM_ack handshake, and reports underrun and missed-deadline conditions.

Parameters:
CLK_PER_SAMPLE, 2268, clocks per audio sample period (100 MHz / 44.1 kHz); must be >= 4
DEPTH, 16, FIFO depth in samples; power of two, >= 2
PCM_W, 16, sample width in bits (signed two's complement)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a sample on in_data
in_data  input  PCM_W  signed producer sample
in_ready  output  1  FIFO can accept; transfer when in_valid && in_ready
PCM_valid  output  1  sample offered to converter
PCM_data  output  PCM_W  signed sample to converter; stable while PCM_valid high
PCM_ack  input  1  converter accepted PCM_data
fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy
underrun  output  1  sticky: a tick found the FIFO empty
missed_tick  output  1  sticky: a tick arrived with the previous offer still unacked
clr_flags  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (rst low, async): FIFO emptied, fill_level=0, in_ready=0 during reset, then 1 in the first cycle after release. PCM_valid=0, PCM_data=0, underrun=0, missed_tick=0, tick counter=0.
- Tick counter: counts 0..CLK_PER_SAMPLE-1, then wraps to 0. tick is asserted in the cycle where count==CLK_PER_SAMPLE-1. The first tick occurs CLK_PER_SAMPLE cycles after reset release.
- Write side: in_ready = (fill_level < DEPTH). A push writes in_data at the write pointer; pointers wrap modulo DEPTH. A push while full is impossible by construction; in_valid with in_ready=0 is ignored.
- Offer FSM, states IDLE and OFFER:
  - IDLE, tick, FIFO non-empty: pop head into PCM_data; PCM_valid=1 from the next cycle; go to OFFER.
  - IDLE, tick, FIFO empty: re-offer the last PCM_data (0 after reset); set underrun; go to OFFER.
  - OFFER: PCM_valid held high and PCM_data held stable until PCM_ack is sampled high. Then PCM_valid=0 in the next cycle; go to IDLE.
  - OFFER, tick, no ack this cycle: set missed_tick, no pop, stay in OFFER. The tick is dropped, not queued.
  - OFFER, tick and ack in the same cycle: ack completes the transfer. The tick is handled as in IDLE, so PCM_valid stays high and the new sample is presented next cycle.
- Latency: tick to PCM_valid = 1 cycle. Producer push to visible in fill_level = 1 cycle.
- Same-cycle push and pop: both occur; fill_level unchanged. A push into an empty FIFO on a tick cycle does not satisfy that tick, so underrun is set.
- clr_flags: clears the flags next cycle. If a set condition occurs in the same cycle, set wins.
- No arithmetic on sample values; data passes bit-exact.
- Reset mid-offer: PCM_valid drops asynchronously and all buffered samples are discarded.

Decomposition:
- Shared package pcm_pkg: PCM_W constant, typedef pcm_sample_t (logic signed [PCM_W-1:0]), default CLK_PER_SAMPLE, and the offer-state enum (IDLE, OFFER). Used by this block and the PCM-to-PWM converter.
- Sub-module sync_fifo (parameters DEPTH and data type): single-clock FIFO with push, pop, full, empty and count.
- Tick counter and offer FSM stay in the top level.

Test Plan:
All cases use CLK_PER_SAMPLE=8, DEPTH=4.
- Reset/idle: hold rst low 3 cycles, release, no input -> all outputs 0; first tick at cycle 8 sets underrun=1; PCM_valid=1 with PCM_data=16'h0000.
- Normal flow: push 16'h8003 and 16'h8008, ack 2 cycles after each PCM_valid -> valid rises 1 cycle after ticks at cycles 8 and 16; data 16'h8003 then 16'h8008; underrun stays 0; fill_level 2 -> 1 -> 0.
- Full FIFO: push 5 samples back-to-back -> in_ready=0 after the 4th push; 5th held until first pop; output order preserved; fill_level never exceeds 4.
- Missed deadline: push 2 samples, never ack -> missed_tick=1 at the second tick; PCM_data stays at the first sample; fill_level stays 1. Then ack -> the next tick presents the second sample.
- Ack coincident with tick: ack exactly on the tick cycle -> PCM_valid stays high continuously; data changes to the next sample in the following cycle; missed_tick stays 0.
- Async reset mid-offer: drop rst while PCM_valid=1 with 3 samples queued -> PCM_valid=0 immediately (before the next clk edge); after release fill_level=0; clr_flags clears both flags.
